// File: rtl/pcie_deskew_pkg.sv
// pcie_deskew_pkg
// Shared definitions for the PCIe lane deskew stage:
//   - COM symbol codes as they appear on the 10-bit lane bus
//   - deskew FSM state encoding (legacy-compatible localparam constants)
//   - helpers: COM detection, legal link-width check, offset counter width
package pcie_deskew_pkg;

  // The two running-disparity forms of the K28.5 COM symbol.
  localparam logic [9:0] COM_POS = 10'h0FA;
  localparam logic [9:0] COM_NEG = 10'h305;

  typedef logic [1:0] deskew_state_t;
  localparam deskew_state_t ST_HUNT    = 2'd0;
  localparam deskew_state_t ST_MEASURE = 2'd1;
  localparam deskew_state_t ST_LOCKED  = 2'd2;

  function automatic logic is_com(input logic [9:0] sym);
    return (sym == COM_POS) || (sym == COM_NEG);
  endfunction

  // Only x1, x2, x4, x8 and x16 links exist, and never wider than the bundle.
  function automatic logic width_legal(input logic [4:0] w, input int lanes);
    logic pow2_ok;
    case (w)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: pow2_ok = 1'b1;
      default:                       pow2_ok = 1'b0;
    endcase
    return pow2_ok && (int'(w) <= lanes);
  endfunction

  // Offsets and delays range over 0..max_skew.
  function automatic int offset_width(input int max_skew);
    return $clog2(max_skew + 1);
  endfunction

endpackage

// File: rtl/pcie_lane_delay.sv
// pcie_lane_delay
// One lane of the deskew delay line: a MAX_SKEW-deep symbol shift register,
// a tap mux selecting "delay" cycles of extra latency, and an output register.
// Total latency from sym_in to sym_out is delay+1 cycles.
// Ports:
//   clk      symbol clock
//   rst_n    asynchronous active-low reset
//   sym_in   10-bit lane symbol from the link
//   delay    tap select, 0..MAX_SKEW (0 = pass straight to the output register)
//   sym_out  registered, delayed lane symbol
module pcie_lane_delay #(
  parameter int MAX_SKEW = 7,
  parameter int DW       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    sym_in,
  input  logic [DW-1:0] delay,
  output logic [9:0]    sym_out
);

  logic [9:0] sr_q [MAX_SKEW];
  logic [9:0] sr_d [MAX_SKEW];
  logic [9:0] tap_s;
  logic [9:0] out_d;
  logic [9:0] out_q;

  // Shift register advance and tap selection; sr_q[k] holds the symbol from k+1 cycles ago.
  always_comb begin
    sr_d[0] = sym_in;
    for (int k = 1; k < MAX_SKEW; k++) begin
      sr_d[k] = sr_q[k-1];
    end
    // One-hot OR mux keeps the selection free of out-of-range indexing.
    tap_s = 10'd0;
    for (int k = 0; k < MAX_SKEW; k++) begin
      tap_s = tap_s | ((delay == DW'(k + 1)) ? sr_q[k] : 10'd0);
    end
    if (delay == {DW{1'b0}}) begin
      out_d = sym_in;
    end else begin
      out_d = tap_s;
    end
  end

  // Delay line and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_SKEW; k++) begin
        sr_q[k] <= 10'd0;
      end
      out_q <= 10'd0;
    end else begin
      for (int k = 0; k < MAX_SKEW; k++) begin
        sr_q[k] <= sr_d[k];
      end
      out_q <= out_d;
    end
  end

  assign sym_out = out_q;

endmodule

// File: rtl/pcie_lane_deskew.sv
// pcie_lane_deskew
// Deskews the PCIe lane bundle: finds COM on every active lane, measures each
// lane's arrival offset relative to the earliest one, and delays early lanes
// so that COMs leave all active lanes together. Lock is monitored on the
// registered output; misalignment or out-of-range skew raises SkewErr.
// Ports:
//   Clk        symbol clock, rising edge
//   notReset   asynchronous active-low reset
//   LinkIn     LANES x 10-bit symbols, lane i at [10i+9:10i]
//   LinkWidth  number of active lanes (1,2,4,8,16); anything else = none active
//   LinkOut    deskewed symbols, same packing as LinkIn
//   Aligned    high while locked
//   SkewErr    one-cycle pulse when lock is lost or skew is out of range
//   Skew       locked skew in cycles, 0 when not locked
module pcie_lane_deskew
  import pcie_deskew_pkg::*;
#(
  parameter int LANES    = 16,
  parameter int MAX_SKEW = 7
) (
  input  logic                 Clk,
  input  logic                 notReset,
  input  logic [LANES*10-1:0]  LinkIn,
  input  logic [4:0]           LinkWidth,
  output logic [LANES*10-1:0]  LinkOut,
  output logic                 Aligned,
  output logic                 SkewErr,
  output logic [3:0]           Skew
);

  localparam int OFFW = offset_width(MAX_SKEW);
  localparam logic [LANES-1:0][OFFW-1:0] ZERO_TBL = {(LANES*OFFW){1'b0}};

  deskew_state_t                state_q, state_d;
  logic [OFFW-1:0]              cnt_q, cnt_d;
  logic [LANES-1:0]             rec_q, rec_d;
  logic [LANES-1:0][OFFW-1:0]   off_q, off_d;
  logic [LANES-1:0][OFFW-1:0]   delay_q, delay_d;
  logic [3:0]                   skew_q, skew_d;
  logic                         aligned_q, aligned_d;
  logic                         err_q, err_d;
  logic [4:0]                   lw_q, lw_d;

  logic                         width_ok_s;
  logic                         width_chg_s;
  logic [LANES-1:0]             active_s;
  logic [LANES-1:0]             com_in_s;
  logic [LANES-1:0]             com_out_s;
  logic [LANES-1:0]             rec_next_s;
  logic [OFFW-1:0]              cnt_next_s;
  logic [LANES*10-1:0]          link_out_s;

  // Lane activity and COM detection on both the raw input and the registered output.
  always_comb begin
    width_ok_s  = width_legal(LinkWidth, LANES);
    width_chg_s = (LinkWidth != lw_q);
    for (int i = 0; i < LANES; i++) begin
      active_s[i]  = width_ok_s && (i < int'(LinkWidth));
      com_in_s[i]  = active_s[i] && is_com(LinkIn[10*i +: 10]);
      com_out_s[i] = active_s[i] && is_com(link_out_s[10*i +: 10]);
    end
  end

  // Deskew FSM with offset bookkeeping and delay computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rec_d      = rec_q;
    off_d      = off_q;
    delay_d    = delay_q;
    skew_d     = skew_q;
    err_d      = 1'b0;
    lw_d       = LinkWidth;
    cnt_next_s = cnt_q + OFFW'(1);
    rec_next_s = rec_q | com_in_s;

    case (state_q)
      ST_HUNT: begin
        delay_d = ZERO_TBL;
        skew_d  = 4'd0;
        cnt_d   = {OFFW{1'b0}};
        off_d   = ZERO_TBL;
        if (|com_in_s) begin
          // Every lane showing COM now is offset 0.
          rec_d = com_in_s;
          if (com_in_s == active_s) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_MEASURE;
          end
        end else begin
          rec_d = {LANES{1'b0}};
        end
      end

      ST_MEASURE: begin
        if (width_chg_s) begin
          state_d = ST_HUNT;
          cnt_d   = {OFFW{1'b0}};
          rec_d   = {LANES{1'b0}};
          off_d   = ZERO_TBL;
          delay_d = ZERO_TBL;
          skew_d  = 4'd0;
        end else begin
          for (int i = 0; i < LANES; i++) begin
            if (com_in_s[i] && !rec_q[i]) begin
              off_d[i] = cnt_next_s;
            end else begin
              off_d[i] = off_q[i];
            end
          end
          rec_d = rec_next_s;
          if ((rec_next_s & active_s) == active_s) begin
            // Lock completes only on a cycle where the last lane(s) arrive, so
            // the maximum offset is always this cycle's offset.
            for (int i = 0; i < LANES; i++) begin
              if (active_s[i]) begin
                delay_d[i] = cnt_next_s - off_d[i];
              end else begin
                delay_d[i] = {OFFW{1'b0}};
              end
            end
            skew_d  = 4'(cnt_next_s);
            state_d = ST_LOCKED;
          end else if (cnt_next_s >= OFFW'(MAX_SKEW)) begin
            // Last in-window cycle has passed with lanes still missing.
            err_d   = 1'b1;
            state_d = ST_HUNT;
            cnt_d   = {OFFW{1'b0}};
            rec_d   = {LANES{1'b0}};
            off_d   = ZERO_TBL;
            delay_d = ZERO_TBL;
            skew_d  = 4'd0;
          end else begin
            cnt_d = cnt_next_s;
          end
        end
      end

      ST_LOCKED: begin
        if (width_chg_s) begin
          state_d = ST_HUNT;
          cnt_d   = {OFFW{1'b0}};
          rec_d   = {LANES{1'b0}};
          off_d   = ZERO_TBL;
          delay_d = ZERO_TBL;
          skew_d  = 4'd0;
        end else if ((|com_out_s) && (com_out_s != active_s)) begin
          // COM on some but not all output lanes: alignment has drifted.
          err_d   = 1'b1;
          state_d = ST_HUNT;
          cnt_d   = {OFFW{1'b0}};
          rec_d   = {LANES{1'b0}};
          off_d   = ZERO_TBL;
          delay_d = ZERO_TBL;
          skew_d  = 4'd0;
        end else begin
          state_d = ST_LOCKED;
        end
      end

      default: begin
        state_d = ST_HUNT;
        cnt_d   = {OFFW{1'b0}};
        rec_d   = {LANES{1'b0}};
        off_d   = ZERO_TBL;
        delay_d = ZERO_TBL;
        skew_d  = 4'd0;
      end
    endcase

    aligned_d = (state_d == ST_LOCKED);
  end

  // FSM and status registers.
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      state_q   <= ST_HUNT;
      cnt_q     <= {OFFW{1'b0}};
      rec_q     <= {LANES{1'b0}};
      off_q     <= ZERO_TBL;
      delay_q   <= ZERO_TBL;
      skew_q    <= 4'd0;
      aligned_q <= 1'b0;
      err_q     <= 1'b0;
      lw_q      <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rec_q     <= rec_d;
      off_q     <= off_d;
      delay_q   <= delay_d;
      skew_q    <= skew_d;
      aligned_q <= aligned_d;
      err_q     <= err_d;
      lw_q      <= lw_d;
    end
  end

  // The lanes see the delay being established this cycle, so the output
  // register already captures the aligned COM on the lock edge.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pcie_lane_delay #(
      .MAX_SKEW (MAX_SKEW),
      .DW       (OFFW)
    ) u_delay (
      .clk     (Clk),
      .rst_n   (notReset),
      .sym_in  (LinkIn[10*g +: 10]),
      .delay   (delay_d[g]),
      .sym_out (link_out_s[10*g +: 10])
    );
  end

  assign LinkOut = link_out_s;
  assign Aligned = aligned_q;
  assign SkewErr = err_q;
  assign Skew    = skew_q;

endmodule

// File: tb/tb_pcie_lane_deskew.sv
// Bench for pcie_lane_deskew: COM sets with chosen per-lane arrival times,
// a timestamp-based reference model, and a scoreboard checked every cycle.
module tb_pcie_lane_deskew;

  localparam int LANES    = 16;
  localparam int MAX_SKEW = 7;
  localparam int W        = LANES * 10;
  localparam int PERIOD   = 20;

  logic         Clk;
  logic         notReset;
  logic [W-1:0] LinkIn;
  logic [4:0]   LinkWidth;
  logic [W-1:0] LinkOut;
  logic         Aligned;
  logic         SkewErr;
  logic [3:0]   Skew;

  pcie_lane_deskew #(.LANES(LANES), .MAX_SKEW(MAX_SKEW)) dut (
    .Clk       (Clk),
    .notReset  (notReset),
    .LinkIn    (LinkIn),
    .LinkWidth (LinkWidth),
    .LinkOut   (LinkOut),
    .Aligned   (Aligned),
    .SkewErr   (SkewErr),
    .Skew      (Skew)
  );

  typedef struct packed {
    logic [W-1:0] out;
    logic         al;
    logic         err;
    logic [3:0]   skew;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: arrival timestamps rather than counters.
  typedef enum int {M_HUNT, M_MEAS, M_LOCK} mmode_t;
  mmode_t       m_mode;
  int           m_arr [LANES];
  int           m_dly [LANES];
  int           m_t0;
  int           m_skew;
  int           m_cyc;
  logic [4:0]   m_lw;
  logic [W-1:0] m_hist [16];
  logic [W-1:0] m_prev;

  int offs [LANES];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic bit sym_is_com(input logic [9:0] s);
    return (s == 10'h0FA) || (s == 10'h305);
  endfunction

  function automatic bit width_ok(input logic [4:0] w);
    return (w == 5'd1 || w == 5'd2 || w == 5'd4 || w == 5'd8 || w == 5'd16) && (int'(w) <= LANES);
  endfunction

  function automatic logic [9:0] data_sym();
    logic [9:0] s;
    do s = 10'($urandom); while (sym_is_com(s));
    return s;
  endfunction

  function automatic logic [9:0] com_sym();
    return ($urandom_range(0, 1) == 0) ? 10'h0FA : 10'h305;
  endfunction

  task automatic model_hunt();
    m_mode = M_HUNT;
    m_skew = 0;
    for (int i = 0; i < LANES; i++) m_dly[i] = 0;
  endtask

  task automatic model_reset();
    model_hunt();
    for (int i = 0; i < 16; i++) m_hist[i] = '0;
    for (int i = 0; i < LANES; i++) m_arr[i] = -1;
    m_prev = '0;
    m_cyc  = 0;
    m_t0   = 0;
    m_lw   = LinkWidth;
  endtask

  // Advance the model by one input cycle and queue the output expected after the edge.
  task automatic model_cycle(input logic [W-1:0] x, input logic [4:0] w);
    bit           act [LANES];
    bit           cin [LANES];
    bit           any_c, all_c, any_o, all_o, err;
    logic [W-1:0] y;
    logic [W-1:0] h;
    exp_t         e;
    err = 1'b0;
    m_hist[m_cyc % 16] = x;
    for (int i = 0; i < LANES; i++) begin
      act[i] = width_ok(w) && (i < int'(w));
      cin[i] = act[i] && sym_is_com(x[10*i +: 10]);
    end
    if (m_mode != M_HUNT && w != m_lw) begin
      model_hunt();
    end else if (m_mode == M_HUNT) begin
      any_c = 1'b0; all_c = 1'b1;
      for (int i = 0; i < LANES; i++)
        if (act[i]) begin
          if (cin[i]) any_c = 1'b1; else all_c = 1'b0;
        end
      if (any_c) begin
        m_t0 = m_cyc;
        for (int i = 0; i < LANES; i++) m_arr[i] = cin[i] ? m_cyc : -1;
        if (all_c) begin m_mode = M_LOCK; m_skew = 0; end
        else m_mode = M_MEAS;
      end
    end else if (m_mode == M_MEAS) begin
      all_c = 1'b1;
      for (int i = 0; i < LANES; i++)
        if (act[i]) begin
          if (cin[i] && m_arr[i] < 0) m_arr[i] = m_cyc;
          if (m_arr[i] < 0) all_c = 1'b0;
        end
      if (all_c) begin
        m_mode = M_LOCK;
        m_skew = m_cyc - m_t0;
        for (int i = 0; i < LANES; i++) m_dly[i] = act[i] ? (m_cyc - m_arr[i]) : 0;
      end else if (m_cyc - m_t0 >= MAX_SKEW) begin
        err = 1'b1;
        model_hunt();
      end
    end else begin
      any_o = 1'b0; all_o = 1'b1;
      for (int i = 0; i < LANES; i++)
        if (act[i]) begin
          if (sym_is_com(m_prev[10*i +: 10])) any_o = 1'b1; else all_o = 1'b0;
        end
      if (any_o && !all_o) begin
        err = 1'b1;
        model_hunt();
      end
    end
    for (int i = 0; i < LANES; i++) begin
      h = m_hist[(m_cyc - m_dly[i]) % 16];
      y[10*i +: 10] = (m_dly[i] == 0) ? x[10*i +: 10] : h[10*i +: 10];
    end
    e.out  = y;
    e.al   = (m_mode == M_LOCK);
    e.err  = err;
    e.skew = 4'(m_skew);
    exp_q.push_back(e);
    m_prev = y;
    m_lw   = w;
    m_cyc++;
  endtask

  task automatic check_vec(input string name, input exp_t got, input exp_t want);
    vectors++;
    if (got.out !== want.out) begin
      miscompares++;
      $display("FAIL %s LinkOut got %h want %h (t=%0t)", name, got.out, want.out, $time);
    end
    if (got.al !== want.al) begin
      miscompares++;
      $display("FAIL %s Aligned got %b want %b (t=%0t)", name, got.al, want.al, $time);
    end
    if (got.err !== want.err) begin
      miscompares++;
      $display("FAIL %s SkewErr got %b want %b (t=%0t)", name, got.err, want.err, $time);
    end
    if (got.skew !== want.skew) begin
      miscompares++;
      $display("FAIL %s Skew got %0d want %0d (t=%0t)", name, got.skew, want.skew, $time);
    end
  endtask

  // Monitor: the DUT presents an output every cycle; compare against the queue head.
  initial begin
    forever begin
      exp_t e, g;
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        g.out  = LinkOut;
        g.al   = Aligned;
        g.err  = SkewErr;
        g.skew = Skew;
        check_vec("scoreboard", g, e);
      end
    end
  end

  task automatic step(input logic [W-1:0] x, input logic [4:0] w);
    @(negedge Clk);
    LinkIn    = x;
    LinkWidth = w;
    model_cycle(x, w);
  endtask

  task automatic build_cycle(input int k, output logic [W-1:0] x);
    for (int i = 0; i < LANES; i++)
      x[10*i +: 10] = (offs[i] == k) ? com_sym() : data_sym();
  endtask

  task automatic run_sets(input logic [4:0] w, input int nsets);
    logic [W-1:0] x;
    for (int s = 0; s < nsets; s++)
      for (int k = 0; k < PERIOD; k++) begin
        build_cycle(k, x);
        step(x, w);
      end
  endtask

  task automatic set_offs(input int lo, input int hi, input int v);
    for (int i = 0; i < LANES; i++) offs[i] = (i >= lo && i <= hi) ? v : -1;
  endtask

  task automatic check_reset_outputs(input string name);
    exp_t g, z;
    g.out = LinkOut; g.al = Aligned; g.err = SkewErr; g.skew = Skew;
    z = '0;
    check_vec(name, g, z);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench timed out");
  end

  logic [4:0] wtab [8] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd3, 5'd0, 5'd12};

  initial begin
    logic [W-1:0] x;
    notReset  = 1'b0;
    LinkIn    = '0;
    LinkWidth = 5'd4;
    #3;
    check_reset_outputs("reset_state");
    @(negedge Clk);
    notReset = 1'b1;
    model_reset();

    // Zero skew, x4.
    set_offs(0, 3, 0);
    run_sets(5'd4, 3);

    // Skew 3: lane 2 early by three cycles.
    set_offs(0, 3, 3);
    offs[2] = 0;
    run_sets(5'd4, 3);

    // Over-range skew (8) then a clean set.
    set_offs(0, 3, 0);
    offs[1] = 8;
    run_sets(5'd4, 2);
    set_offs(0, 3, 0);
    run_sets(5'd4, 2);

    // Skew exactly MAX_SKEW: last lane arrives in the timeout cycle.
    set_offs(0, 3, 0);
    offs[1] = MAX_SKEW;
    run_sets(5'd4, 3);

    // Drift while locked: lane 3 slips one cycle.
    set_offs(0, 3, 0);
    run_sets(5'd4, 2);
    offs[3] = 1;
    run_sets(5'd4, 3);

    // Lock at x8, then narrow to x4 while locked.
    set_offs(0, 7, 0);
    for (int i = 0; i < 8; i++) offs[i] = $urandom_range(0, 3);
    run_sets(5'd8, 2);
    run_sets(5'd4, 2);

    // Reset asserted in MEASURE.
    step(x, 5'd2);
    set_offs(0, 3, 5);
    offs[0] = 0;
    for (int k = 0; k < 3; k++) begin
      build_cycle(k, x);
      step(x, 5'd4);
    end
    @(negedge Clk);
    LinkIn   = '0;
    notReset = 1'b0;
    #1;
    check_reset_outputs("reset_in_measure");
    repeat (2) @(negedge Clk);
    notReset = 1'b1;
    model_reset();
    set_offs(0, 3, 2);
    offs[1] = 0;
    run_sets(5'd4, 2);

    // Randomized widths (including illegal ones) and arrival offsets.
    for (int n = 0; n < 14; n++) begin
      logic [4:0] w;
      w = wtab[$urandom_range(0, 7)];
      for (int i = 0; i < LANES; i++)
        offs[i] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(8, 9)) : int'($urandom_range(0, 4));
      run_sets(w, 2);
    end

    @(posedge Clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain %0d expected outputs never checked (want 0)", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
